// File: rtl/mx_elem_dequant.sv
// MX element dequantiser: turns one low-precision float element plus its block's
// shared E8M0 scale into a signed fixed-point value through a two-stage pipeline.
module mx_elem_dequant #(
   parameter int width_o_exp = 4,
   parameter int width_o_man = 3,
   parameter int width_scale = 8,
   parameter int blk_size    = 32,
   parameter bit e4m3_spec   = (width_o_exp == 4) && (width_o_man == 3),
   localparam int max_exp_elem = (2 ** width_o_exp) - 1 - (e4m3_spec ? 0 : 1),
   localparam int width_o      = 2 + width_o_man + max_exp_elem
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic                   i_first,
   input  logic [width_scale-1:0] i_scale,
   input  logic                   i_sign,
   input  logic [width_o_exp-1:0] i_exp,
   input  logic [width_o_man-1:0] i_man,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [width_o-1:0]     o_num,
   output logic [width_scale-1:0] o_scale,
   output logic                   o_nan,
   output logic                   o_inf,
   output logic                   o_last,
   output logic                   o_err
);

   localparam int cnt_w = (blk_size > 1) ? $clog2(blk_size) : 1;
   localparam logic [cnt_w-1:0] last_idx = cnt_w'(blk_size - 1);
   localparam logic [width_scale-1:0] unity_scale = {1'b0, {(width_scale-1){1'b1}}};

   logic                   s1_valid, s2_valid, s1_adv, s2_adv, accept;
   logic [cnt_w-1:0]       cnt, idx;
   logic [width_scale-1:0] scale_reg, elem_scale;
   logic                   elem_err, elem_last, elem_nan, elem_inf;
   logic                   exp_ones, man_zero, man_ones;

   logic                   s1_sign, s1_nan, s1_inf, s1_last, s1_err;
   logic [width_o_exp-1:0] s1_exp;
   logic [width_o_man-1:0] s1_man;
   logic [width_scale-1:0] s1_scale;

   logic [width_o_man:0]   mant;
   logic [width_o-1:0]     mag, num_next;

   assign s2_adv  = !s2_valid || i_ready;
   assign s1_adv  = s1_valid && s2_adv;
   assign o_ready = !s1_valid || s1_adv;
   assign accept  = i_valid && o_ready;
   assign o_valid = s2_valid;

   // A first flag mid-block restarts indexing at zero and flags the restart.
   always_comb begin
      idx        = i_first ? '0 : cnt;
      elem_err   = i_first && (cnt != '0);
      elem_last  = (idx == last_idx);
      elem_scale = i_first ? i_scale : scale_reg;
      exp_ones   = &i_exp;
      man_zero   = ~|i_man;
      man_ones   = &i_man;
      elem_inf   = 1'b0;
      if (e4m3_spec) begin
         elem_nan = (exp_ones && man_ones) || (&elem_scale);
      end else begin
         elem_nan = (exp_ones && !man_zero) || (&elem_scale);
         elem_inf = exp_ones && man_zero && !(&elem_scale);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt       <= '0;
         scale_reg <= unity_scale;
      end else if (accept) begin
         cnt <= elem_last ? '0 : idx + cnt_w'(1);
         if (i_first) scale_reg <= i_scale;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_exp   <= '0;
         s1_man   <= '0;
         s1_scale <= unity_scale;
         s1_nan   <= 1'b0;
         s1_inf   <= 1'b0;
         s1_last  <= 1'b0;
         s1_err   <= 1'b0;
      end else if (o_ready) begin
         s1_valid <= i_valid;
         if (i_valid) begin
            s1_sign  <= i_sign;
            s1_exp   <= i_exp;
            s1_man   <= i_man;
            s1_scale <= elem_scale;
            s1_nan   <= elem_nan;
            s1_inf   <= elem_inf;
            s1_last  <= elem_last;
            s1_err   <= elem_err;
         end
      end
   end

   // Hidden bit is set for normals; subnormals use the raw mantissa unshifted.
   always_comb begin
      mant = {(s1_exp != '0), s1_man};
      mag  = width_o'(mant);
      if (s1_exp != '0) mag = mag << (s1_exp - width_o_exp'(1));
      if (s1_nan || s1_inf) num_next = '0;
      else                  num_next = s1_sign ? -mag : mag;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s2_valid <= 1'b0;
         o_num    <= '0;
         o_scale  <= unity_scale;
         o_nan    <= 1'b0;
         o_inf    <= 1'b0;
         o_last   <= 1'b0;
         o_err    <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            o_num   <= num_next;
            o_scale <= s1_scale;
            o_nan   <= s1_nan;
            o_inf   <= s1_inf;
            o_last  <= s1_last;
            o_err   <= s1_err;
         end
      end
   end

endmodule

// File: tb/tb_mx_elem_dequant.sv
// Randomised bench for mx_elem_dequant: a real-arithmetic reference model predicts
// each element's value and block bookkeeping; outputs are collected and compared.
module tb_mx_elem_dequant;

   localparam int W = 20;

   logic         i_clk, i_rst_n, i_valid, o_ready, i_first, i_sign;
   logic [7:0]   i_scale, o_scale;
   logic [3:0]   i_exp;
   logic [2:0]   i_man;
   logic         o_valid, i_ready, o_nan, o_inf, o_last, o_err;
   logic [W-1:0] o_num;

   mx_elem_dequant dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_first(i_first), .i_scale(i_scale), .i_sign(i_sign), .i_exp(i_exp),
      .i_man(i_man), .o_valid(o_valid), .i_ready(i_ready), .o_num(o_num),
      .o_scale(o_scale), .o_nan(o_nan), .o_inf(o_inf), .o_last(o_last), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int num;
      int scale;
      bit nan;
      bit inf;
      bit last;
      bit err;
      int cyc;
   } rec_t;

   rec_t exp_q[$];
   rec_t obs_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   ncyc = 0;
   int   acc_cyc = 0;
   bit   accepted = 0;
   int   model_pos = 0;
   int   model_scale = 127;
   bit   prev_stalled = 0;
   int   stall_viol = 0;
   logic [W-1:0] prev_num;
   logic [7:0]   prev_scale;
   logic [3:0]   prev_flags;

   bit   blk_s[32];
   int   blk_e[32];
   int   blk_m[32];
   int   blk_scale;
   int   btb_num[32];

   // Reference: value = (-1)^s * 1.m * 2^(e-bias), or 0.m * 2^(1-bias) for e==0, scaled by 2^9.
   function automatic rec_t model(bit first, int scale, bit s, int e, int m);
      rec_t r;
      int   idx;
      real  v;
      idx       = first ? 0 : model_pos;
      r.err     = first && (model_pos != 0);
      r.last    = (idx == 31);
      model_pos = r.last ? 0 : idx + 1;
      if (first) model_scale = scale;
      r.scale = model_scale;
      r.nan   = (e == 15 && m == 7) || (model_scale == 255);
      r.inf   = 0;
      r.cyc   = 0;
      if (r.nan) r.num = 0;
      else begin
         if (e == 0) v = (m / 8.0) * $pow(2.0, -6.0);
         else        v = (1.0 + m / 8.0) * $pow(2.0, e - 7.0);
         if (s) v = -v;
         r.num = $rtoi(v * 512.0);
      end
      return r;
   endfunction

   task automatic clear_model();
      exp_q.delete();
      obs_q.delete();
      model_pos    = 0;
      model_scale  = 127;
      prev_stalled = 0;
      stall_viol   = 0;
   endtask

   task automatic cycle();
      rec_t o;
      @(negedge i_clk);
      ncyc++;
      if (prev_stalled) begin
         if (o_valid !== 1'b1 || o_num !== prev_num || o_scale !== prev_scale ||
             {o_nan, o_inf, o_last, o_err} !== prev_flags) stall_viol++;
      end
      prev_stalled = (o_valid === 1'b1) && !i_ready;
      prev_num     = o_num;
      prev_scale   = o_scale;
      prev_flags   = {o_nan, o_inf, o_last, o_err};
      if (o_valid === 1'b1 && i_ready) begin
         o.num = int'($signed(o_num)); o.scale = int'(o_scale);
         o.nan = o_nan; o.inf = o_inf; o.last = o_last; o.err = o_err; o.cyc = ncyc;
         obs_q.push_back(o);
      end
      accepted = (i_valid === 1'b1) && (o_ready === 1'b1);
      if (accepted) begin
         acc_cyc = ncyc;
         exp_q.push_back(model(i_first, int'(i_scale), i_sign, int'(i_exp), int'(i_man)));
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst_n = 0;
      i_valid = 0;
      i_ready = 1;
      #2;
      i_rst_n = 1;
      clear_model();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(bit first, int scale, bit s, int e, int m, bit rand_ready);
      int budget;
      i_valid = 1; i_first = first; i_scale = 8'(scale);
      i_sign = s; i_exp = 4'(e); i_man = 3'(m);
      budget = 0;
      do begin
         if (rand_ready) i_ready = 1'($urandom % 2);
         cycle();
         budget++;
      end while (!accepted && budget < 200);
      if (!accepted) begin
         vectors++; miscompares++;
         $display("[TB] FAIL send_timeout: accepted=0 required=1");
      end
      i_valid = 0;
   endtask

   task automatic drain();
      int budget;
      i_valid = 0;
      i_ready = 1;
      budget = 0;
      while (obs_q.size() < exp_q.size() && budget < 100) begin
         cycle();
         budget++;
      end
      repeat (4) cycle();
   endtask

   task automatic test_reset();
      i_rst_n = 0; i_valid = 0; i_ready = 1; i_first = 0;
      i_scale = 0; i_sign = 0; i_exp = 0; i_man = 0;
      #2;
      vectors++;
      if (o_valid !== 1'b0) begin
         miscompares++; $display("[TB] FAIL reset_valid: got=%b want=0", o_valid);
      end
      vectors++;
      if (o_num !== '0) begin
         miscompares++; $display("[TB] FAIL reset_num: got=%0d want=0", o_num);
      end
      vectors++;
      if ({o_last, o_err, o_nan, o_inf} !== 4'b0) begin
         miscompares++; $display("[TB] FAIL reset_flags: got=%b want=0000", {o_last, o_err, o_nan, o_inf});
      end
      @(posedge i_clk); #1;
      i_rst_n = 1;
      @(negedge i_clk);
      vectors++;
      if (o_ready !== 1'b1) begin
         miscompares++; $display("[TB] FAIL reset_ready: got=%b want=1", o_ready);
      end
      @(posedge i_clk); #1;
   endtask

   task automatic test_directed();
      int first_acc;
      do_reset();
      send(1, 8'h7F, 0, 7, 0, 0);
      first_acc = acc_cyc;
      send(0, 0, 1, 15, 6, 0);
      send(0, 0, 0, 0, 1, 0);
      send(0, 0, 1, 0, 0, 0);
      send(0, 0, 0, 15, 7, 0);
      send(1, 8'hFF, 0, 7, 0, 0);
      drain();
      vectors++;
      if (obs_q.size() != 6) begin
         miscompares++; $display("[TB] FAIL directed_count: got=%0d want=6", obs_q.size());
      end else begin
         foreach (obs_q[k]) begin
            vectors++;
            if (obs_q[k].num != exp_q[k].num || obs_q[k].scale != exp_q[k].scale ||
                obs_q[k].nan != exp_q[k].nan || obs_q[k].inf != exp_q[k].inf ||
                obs_q[k].last != exp_q[k].last || obs_q[k].err != exp_q[k].err) begin
               miscompares++;
               $display("[TB] FAIL directed_elem%0d: got num=%0d scale=%0d nan=%b want num=%0d scale=%0d nan=%b",
                        k, obs_q[k].num, obs_q[k].scale, obs_q[k].nan, exp_q[k].num, exp_q[k].scale, exp_q[k].nan);
            end
         end
         vectors++;
         if (obs_q[0].num != 512 || obs_q[0].nan || obs_q[0].scale != 127) begin
            miscompares++; $display("[TB] FAIL unity_one: got=%0d want=512", obs_q[0].num);
         end
         vectors++;
         if (obs_q[0].cyc != first_acc + 2) begin
            miscompares++; $display("[TB] FAIL latency: got=%0d want=2", obs_q[0].cyc - first_acc);
         end
         vectors++;
         if (obs_q[1].num != -229376) begin
            miscompares++; $display("[TB] FAIL max_neg: got=%0d want=-229376", obs_q[1].num);
         end
         vectors++;
         if (obs_q[2].num != 1 || obs_q[3].num != 0) begin
            miscompares++; $display("[TB] FAIL subnormal_zero: got=%0d,%0d want=1,0", obs_q[2].num, obs_q[3].num);
         end
         vectors++;
         if (!obs_q[4].nan || obs_q[4].num != 0 || !obs_q[5].nan) begin
            miscompares++; $display("[TB] FAIL nan_codes: got=%b,%0d,%b want=1,0,1", obs_q[4].nan, obs_q[4].num, obs_q[5].nan);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      blk_scale = int'($urandom_range(0, 254));
      for (int k = 0; k < 32; k++) begin
         blk_s[k] = 1'($urandom % 2);
         blk_e[k] = int'($urandom_range(0, 15));
         blk_m[k] = int'($urandom_range(0, 7));
         send(k == 0, blk_scale, blk_s[k], blk_e[k], blk_m[k], 0);
      end
      drain();
      vectors++;
      if (obs_q.size() != 32 || exp_q.size() != 32) begin
         miscompares++; $display("[TB] FAIL b2b_count: got=%0d want=32", obs_q.size());
      end else begin
         foreach (obs_q[k]) begin
            btb_num[k] = obs_q[k].num;
            vectors++;
            if (obs_q[k].num != exp_q[k].num || obs_q[k].scale != exp_q[k].scale ||
                obs_q[k].nan != exp_q[k].nan || obs_q[k].last != (k == 31) ||
                obs_q[k].err || obs_q[k].cyc != obs_q[0].cyc + k) begin
               miscompares++;
               $display("[TB] FAIL b2b_elem%0d: got num=%0d last=%b cyc=%0d want num=%0d last=%b cyc=%0d",
                        k, obs_q[k].num, obs_q[k].last, obs_q[k].cyc, exp_q[k].num, k == 31, obs_q[0].cyc + k);
            end
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      for (int k = 0; k < 32; k++) send(k == 0, blk_scale, blk_s[k], blk_e[k], blk_m[k], 1);
      drain();
      vectors++;
      if (obs_q.size() != 32) begin
         miscompares++; $display("[TB] FAIL stall_count: got=%0d want=32", obs_q.size());
      end else begin
         foreach (obs_q[k]) begin
            vectors++;
            if (obs_q[k].num != exp_q[k].num || obs_q[k].num != btb_num[k] ||
                obs_q[k].last != exp_q[k].last || obs_q[k].nan != exp_q[k].nan) begin
               miscompares++;
               $display("[TB] FAIL stall_elem%0d: got num=%0d last=%b want num=%0d last=%b",
                        k, obs_q[k].num, obs_q[k].last, exp_q[k].num, exp_q[k].last);
            end
         end
      end
      vectors++;
      if (stall_viol != 0) begin
         miscompares++; $display("[TB] FAIL stall_stable: got=%0d changes want=0", stall_viol);
      end
   endtask

   task automatic test_restart();
      int scale_a, scale_b, nlast;
      do_reset();
      scale_a = int'($urandom_range(0, 254));
      scale_b = int'($urandom_range(0, 254));
      for (int k = 0; k < 5; k++)
         send(k == 0, scale_a, 1'($urandom % 2), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 0);
      send(1, scale_b, 0, int'($urandom_range(1, 14)), int'($urandom_range(0, 7)), 0);
      for (int k = 0; k < 31; k++)
         send(0, 0, 1'($urandom % 2), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 1);
      drain();
      vectors++;
      if (obs_q.size() != 37) begin
         miscompares++; $display("[TB] FAIL restart_count: got=%0d want=37", obs_q.size());
      end else begin
         nlast = 0;
         foreach (obs_q[k]) begin
            nlast += obs_q[k].last;
            vectors++;
            if (obs_q[k].num != exp_q[k].num || obs_q[k].scale != exp_q[k].scale ||
                obs_q[k].err != exp_q[k].err || obs_q[k].last != exp_q[k].last) begin
               miscompares++;
               $display("[TB] FAIL restart_elem%0d: got num=%0d err=%b last=%b want num=%0d err=%b last=%b",
                        k, obs_q[k].num, obs_q[k].err, obs_q[k].last, exp_q[k].num, exp_q[k].err, exp_q[k].last);
            end
         end
         vectors++;
         if (!obs_q[5].err || !obs_q[36].last || nlast != 1 || obs_q[4].scale != scale_a) begin
            miscompares++;
            $display("[TB] FAIL restart_marks: got err5=%b last36=%b nlast=%0d want 1,1,1", obs_q[5].err, obs_q[36].last, nlast);
         end
      end
   endtask

   task automatic test_reset_inflight();
      do_reset();
      i_ready = 0;
      send(1, 8'h20, 0, 3, 1, 0);
      send(0, 0, 1, 9, 4, 0);
      cycle();
      vectors++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
         miscompares++; $display("[TB] FAIL inflight_full: got valid=%b ready=%b want 1,0", o_valid, o_ready);
      end
      #2;
      i_rst_n = 0;
      #1;
      vectors++;
      if (o_valid !== 1'b0) begin
         miscompares++; $display("[TB] FAIL async_reset: got=%b want=0", o_valid);
      end
      @(posedge i_clk); #1;
      i_rst_n = 1;
      clear_model();
      i_ready = 1;
      repeat (4) cycle();
      vectors++;
      if (obs_q.size() != 0) begin
         miscompares++; $display("[TB] FAIL stale_output: got=%0d want=0", obs_q.size());
      end
      send(0, 8'h55, 0, 7, 0, 0);
      drain();
      vectors++;
      if (obs_q.size() != 1) begin
         miscompares++; $display("[TB] FAIL post_reset_count: got=%0d want=1", obs_q.size());
      end else begin
         vectors++;
         if (obs_q[0].num != exp_q[0].num || obs_q[0].scale != 127 || obs_q[0].err || obs_q[0].num != 512) begin
            miscompares++;
            $display("[TB] FAIL post_reset_elem: got num=%0d scale=%0d err=%b want num=512 scale=127 err=0",
                     obs_q[0].num, obs_q[0].scale, obs_q[0].err);
         end
      end
   endtask

   initial begin
      i_clk = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_restart();
      test_reset_inflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
